// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage constants and types for the physical register free list.
// Provides the tag type and a popcount helper for thermometer request vectors.
package phys_free_list_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int FL_ALLOC_W    = 2;
    localparam int FL_FREE_W     = 2;
    localparam int PHYS_TAG_W    = $clog2(NUM_PHYS_REGS);

    typedef logic [PHYS_TAG_W-1:0] preg_t;

    // Widest request vector the popcount helper accepts; callers zero-extend into it.
    localparam int POPCNT_W = 8;

    function automatic logic [3:0] popcount(input logic [POPCNT_W-1:0] v);
        popcount = '0;
        for (int i = 0; i < POPCNT_W; i++) begin
            popcount = popcount + 4'(v[i]);
        end
    endfunction

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with a speculative head for rename,
// a committed head for mispredict rollback, and a tail fed by ROB commit.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int NUM_PREGS = NUM_PHYS_REGS,
    parameter int NUM_AREGS = NUM_ARCH_REGS,
    parameter int ALLOC_W   = FL_ALLOC_W,
    parameter int FREE_W    = FL_FREE_W,
    localparam int ENTRIES  = NUM_PREGS - NUM_AREGS,
    localparam int PREG_W   = $clog2(NUM_PREGS),
    localparam int PTR_W    = $clog2(ENTRIES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ALLOC_W-1:0]        alloc_req,
    output logic                      alloc_ready,
    output logic [ALLOC_W*PREG_W-1:0] alloc_paddr,
    input  logic [FREE_W-1:0]         commit_valid,
    input  logic [FREE_W*PREG_W-1:0]  commit_old_paddr,
    input  logic                      flush,
    output logic [PTR_W-1:0]          free_count,
    output logic                      empty
);

    localparam int IDX_W = PTR_W - 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PREG_W-1:0] entry_q [ENTRIES];
    ptr_t              spec_head_q;
    ptr_t              commit_head_q;
    ptr_t              tail_q;

    ptr_t              n_alloc;
    ptr_t              n_free;
    ptr_t              free_cnt;
    ptr_t              in_flight;
    logic              alloc_fire;
    logic [IDX_W-1:0]  wr_idx [FREE_W];

    assign n_alloc   = PTR_W'(popcount(POPCNT_W'(alloc_req)));
    assign n_free    = PTR_W'(popcount(POPCNT_W'(commit_valid)));
    assign free_cnt  = tail_q - spec_head_q;
    assign in_flight = spec_head_q - commit_head_q;

    // Readiness deliberately ignores this cycle's frees: a released tag only becomes visible next cycle.
    assign alloc_ready = (free_cnt >= PTR_W'(ALLOC_W));
    assign alloc_fire  = alloc_ready & (|alloc_req) & ~flush;
    assign free_count  = free_cnt;
    assign empty       = (free_cnt == '0);

    for (genvar i = 0; i < ALLOC_W; i++) begin : g_rd
        ptr_t rd_ptr;
        assign rd_ptr = spec_head_q + PTR_W'(i);
        assign alloc_paddr[i*PREG_W +: PREG_W] = entry_q[rd_ptr[IDX_W-1:0]];
    end

    for (genvar i = 0; i < FREE_W; i++) begin : g_wr
        ptr_t wr_ptr;
        assign wr_ptr    = tail_q + PTR_W'(i);
        assign wr_idx[i] = wr_ptr[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset on purpose; the list must come up full of the non-architectural tags.
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= PREG_W'(NUM_AREGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= PTR_W'(ENTRIES);
        end else begin
            for (int i = 0; i < FREE_W; i++) begin
                if (commit_valid[i]) begin
                    entry_q[wr_idx[i]] <= commit_old_paddr[i*PREG_W +: PREG_W];
                end
            end
            // Rollback folds in this cycle's commits so the restored head lands past them.
            if (flush) begin
                spec_head_q <= commit_head_q + n_free;
            end else if (alloc_fire) begin
                spec_head_q <= spec_head_q + n_alloc;
            end
            commit_head_q <= commit_head_q + n_free;
            tail_q        <= tail_q + n_free;
        end
    end

    a_alloc_thermo: assert property (@(posedge clk) disable iff (!rst)
        (alloc_req & (alloc_req + ALLOC_W'(1))) == '0);

    a_commit_thermo: assert property (@(posedge clk) disable iff (!rst)
        (commit_valid & (commit_valid + FREE_W'(1))) == '0);

    a_no_overfill: assert property (@(posedge clk) disable iff (!rst)
        (int'(free_cnt) + int'(n_free)) <= ENTRIES);

    a_commit_behind_spec: assert property (@(posedge clk) disable iff (!rst)
        int'(n_free) <= int'(in_flight));

    for (genvar i = 0; i < FREE_W; i++) begin : g_chk
        a_no_zero_tag: assert property (@(posedge clk) disable iff (!rst)
            !(commit_valid[i] && (commit_old_paddr[i*PREG_W +: PREG_W] == '0)));
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed and model-driven bench for phys_free_list with default parameters.
module tb_phys_free_list;
    import phys_free_list_pkg::*;

    localparam int NA  = 32;
    localparam int NP  = 64;
    localparam int ENT = 32;
    localparam int AW  = 2;
    localparam int FW  = 2;
    localparam int PW  = 6;
    localparam int TW  = 6;

    typedef struct {
        int rd;
        int nw;
        int old;
    } rob_e_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [AW-1:0]    alloc_req = '0;
    logic             alloc_ready;
    logic [AW*PW-1:0] alloc_paddr;
    logic [FW-1:0]    commit_valid = '0;
    logic [FW*PW-1:0] commit_old_paddr = '0;
    logic             flush = 1'b0;
    logic [TW-1:0]    free_count;
    logic             empty;

    int n_checks = 0;
    int n_fail   = 0;

    phys_free_list dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req        (alloc_req),
        .alloc_ready      (alloc_ready),
        .alloc_paddr      (alloc_paddr),
        .commit_valid     (commit_valid),
        .commit_old_paddr (commit_old_paddr),
        .flush            (flush),
        .free_count       (free_count),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ar, input logic [1:0] cv,
                         input int t0, input int t1, input logic fl);
        alloc_req        = ar;
        commit_valid     = cv;
        commit_old_paddr = {PW'(t1), PW'(t0)};
        flush            = fl;
    endtask

    task automatic apply_reset();
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // Observation word: {ready, empty, free_count, lane1, lane0}.
    function automatic logic [19:0] obs();
        return {alloc_ready, empty, free_count, alloc_paddr};
    endfunction

    function automatic logic [19:0] want(input logic r, input logic e, input int fc,
                                         input int p1, input int p0);
        return {r, e, TW'(fc), PW'(p1), PW'(p0)};
    endfunction

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (obs() !== want(1, 0, 32, 33, 32)) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs(), want(1, 0, 32, 33, 32));
        end
    endtask

    task automatic test_alloc_drain();
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        tick();
        n_checks++;
        if (obs() !== want(1, 0, 30, 35, 34)) begin
            n_fail++;
            $display("FAIL first_alloc: got %h want %h", obs(), want(1, 0, 30, 35, 34));
        end
        repeat (14) tick();
        n_checks++;
        if (obs() !== want(1, 0, 2, 63, 62)) begin
            n_fail++;
            $display("FAIL alloc_fc2: got %h want %h", obs(), want(1, 0, 2, 63, 62));
        end
        tick();
        n_checks++;
        if (obs() >> 12 !== want(0, 1, 0, 0, 0) >> 12) begin
            n_fail++;
            $display("FAIL alloc_empty: got %h want %h", obs() >> 12, want(0, 1, 0, 0, 0) >> 12);
        end
        tick();
        n_checks++;
        if (obs() >> 12 !== want(0, 1, 0, 0, 0) >> 12) begin
            n_fail++;
            $display("FAIL alloc_hold_empty: got %h want %h", obs() >> 12, want(0, 1, 0, 0, 0) >> 12);
        end
    endtask

    task automatic test_commit_no_bypass();
        drive(2'b00, 2'b01, 5, 0, 1'b0);
        tick();
        n_checks++;
        if ({alloc_ready, empty, free_count, alloc_paddr[PW-1:0]} !== {1'b0, 1'b0, TW'(1), PW'(5)}) begin
            n_fail++;
            $display("FAIL commit_fc1: got rdy=%0b empty=%0b fc=%0d p0=%0d want rdy=0 empty=0 fc=1 p0=5",
                     alloc_ready, empty, free_count, alloc_paddr[PW-1:0]);
        end
        drive(2'b11, 2'b01, 7, 0, 1'b0);
        tick();
        n_checks++;
        if (obs() !== want(1, 0, 2, 7, 5)) begin
            n_fail++;
            $display("FAIL commit_no_bypass: got %h want %h", obs(), want(1, 0, 2, 7, 5));
        end
        drive(2'b01, 2'b00, 0, 0, 1'b0);
        tick();
        n_checks++;
        if ({free_count, alloc_paddr[PW-1:0]} !== {TW'(1), PW'(7)}) begin
            n_fail++;
            $display("FAIL single_lane_alloc: got fc=%0d p0=%0d want fc=1 p0=7",
                     free_count, alloc_paddr[PW-1:0]);
        end
        drive(2'b00, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic test_flush();
        apply_reset();
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        repeat (5) tick();
        drive(2'b00, 2'b11, 1, 2, 1'b0);
        tick();
        drive(2'b00, 2'b11, 3, 4, 1'b0);
        tick();
        n_checks++;
        if (free_count !== TW'(26)) begin
            n_fail++;
            $display("FAIL pre_flush_fc: got %0d want 26", free_count);
        end
        drive(2'b11, 2'b11, 5, 6, 1'b1);
        tick();
        n_checks++;
        if (obs() !== want(1, 0, 32, 39, 38)) begin
            n_fail++;
            $display("FAIL flush_restore: got %h want %h", obs(), want(1, 0, 32, 39, 38));
        end
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        tick();
        n_checks++;
        if (obs() !== want(1, 0, 30, 41, 40)) begin
            n_fail++;
            $display("FAIL post_flush_alloc: got %h want %h", obs(), want(1, 0, 30, 41, 40));
        end
        drive(2'b00, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        rob_e_t        rob[$];
        rob_e_t        pend[$];
        int            q[$];
        int            dut_tags[$];
        int            cmap[NA];
        int            smap[NA];
        int            cnt[NP];
        int            nc, na, exp_fc, bad, lim;
        logic          exp_rdy, fire, fl, dup;
        logic [1:0]    ar, cv;
        apply_reset();
        for (int i = 0; i < ENT; i++) q.push_back(NA + i);
        for (int i = 0; i < NA; i++) begin
            cmap[i] = i;
            smap[i] = i;
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            exp_fc  = ENT - rob.size();
            exp_rdy = (exp_fc >= AW);
            n_checks++;
            if (free_count !== TW'(exp_fc) || alloc_ready !== exp_rdy || empty !== (exp_fc == 0)) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: got fc=%0d rdy=%0b empty=%0b want fc=%0d rdy=%0b",
                         cyc, free_count, alloc_ready, empty, exp_fc, exp_rdy);
            end
            if (exp_rdy) begin
                n_checks++;
                if (alloc_paddr[PW-1:0] !== PW'(q[rob.size()]) ||
                    alloc_paddr[2*PW-1:PW] !== PW'(q[rob.size()+1])) begin
                    n_fail++;
                    $display("FAIL rand_paddr cyc %0d: got {%0d,%0d} want {%0d,%0d}", cyc,
                             alloc_paddr[2*PW-1:PW], alloc_paddr[PW-1:0], q[rob.size()+1], q[rob.size()]);
                end
                dup = 1'b0;
                for (int a = 0; a < NA; a++) begin
                    if (PW'(smap[a]) === alloc_paddr[PW-1:0] || PW'(smap[a]) === alloc_paddr[2*PW-1:PW])
                        dup = 1'b1;
                end
                n_checks++;
                if (dup !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_dup_tag cyc %0d: offered tag is live: got {%0d,%0d}", cyc,
                             alloc_paddr[2*PW-1:PW], alloc_paddr[PW-1:0]);
                end
            end
            fl   = ($urandom_range(0, 11) == 0);
            na   = $urandom_range(0, 2);
            ar   = (na == 0) ? 2'b00 : (na == 1) ? 2'b01 : 2'b11;
            lim  = (rob.size() < FW) ? rob.size() : FW;
            nc   = $urandom_range(0, lim);
            cv   = (nc == 0) ? 2'b00 : (nc == 1) ? 2'b01 : 2'b11;
            fire = exp_rdy && (na > 0) && !fl;
            pend.delete();
            if (fire) begin
                for (int i = 0; i < na; i++) begin
                    rob_e_t e;
                    e.rd  = $urandom_range(1, NA - 1);
                    e.nw  = q[rob.size() + i];
                    e.old = smap[e.rd];
                    smap[e.rd] = e.nw;
                    pend.push_back(e);
                end
            end
            drive(ar, cv, (nc > 0) ? rob[0].old : 0, (nc > 1) ? rob[1].old : 0, fl);
            tick();
            for (int i = 0; i < nc; i++) begin
                rob_e_t e;
                e = rob.pop_front();
                cmap[e.rd] = e.nw;
                void'(q.pop_front());
                q.push_back(e.old);
            end
            if (fl) begin
                rob.delete();
                smap = cmap;
            end else begin
                foreach (pend[i]) rob.push_back(pend[i]);
            end
        end
        for (int k = 0; k < 40 && rob.size() > 0; k++) begin
            nc = (rob.size() < FW) ? rob.size() : FW;
            cv = (nc == 1) ? 2'b01 : 2'b11;
            drive(2'b00, cv, rob[0].old, (nc > 1) ? rob[1].old : 0, 1'b0);
            tick();
            for (int i = 0; i < nc; i++) begin
                rob_e_t e;
                e = rob.pop_front();
                cmap[e.rd] = e.nw;
                void'(q.pop_front());
                q.push_back(e.old);
            end
        end
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        n_checks++;
        if (rob.size() != 0 || free_count !== TW'(ENT)) begin
            n_fail++;
            $display("FAIL rand_drain: got fc=%0d rob=%0d want fc=%0d rob=0", free_count, rob.size(), ENT);
        end
        for (int k = 0; k < ENT / AW; k++) begin
            dut_tags.push_back(int'(alloc_paddr[PW-1:0]));
            dut_tags.push_back(int'(alloc_paddr[2*PW-1:PW]));
            drive(2'b11, 2'b00, 0, 0, 1'b0);
            tick();
        end
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < ENT; i++) if (dut_tags[i] != q[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_list_order: got %0d entries out of order want 0", bad);
        end
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < NA; i++) cnt[cmap[i]]++;
        foreach (dut_tags[i]) cnt[dut_tags[i]]++;
        bad = 0;
        foreach (cnt[i]) if (cnt[i] != 1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_conservation: got %0d tags not held exactly once want 0", bad);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(2'b11, 2'b00, 0, 0, 1'b0);
        repeat (3) tick();
        #2;
        drive(2'b00, 2'b00, 0, 0, 1'b1);
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== want(1, 0, 32, 33, 32)) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs(), want(1, 0, 32, 33, 32));
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, 1'b0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs() !== want(1, 0, 32, 33, 32)) begin
            n_fail++;
            $display("FAIL reset_release_edge: got %h want %h", obs(), want(1, 0, 32, 33, 32));
        end
    endtask

    initial begin
        test_reset();
        test_alloc_drain();
        test_commit_no_bypass();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
